// File: rtl/dcache_assoc_if.sv
// CPU-side and memory-side bus of the set-associative write-back data cache.
// The cache takes the slave view; the CPU/memory environment takes the master view.
interface dcache_assoc_if #(
  parameter int unsigned BLOCK_WORDS = 4
);
  localparam int unsigned OFF = $clog2(BLOCK_WORDS) + 2;

  logic                        read;
  logic                        write;
  logic [3:0]                  byteenable;
  logic [31:0]                 address;
  logic [31:0]                 writedata;
  logic [31:0]                 readdata;
  logic                        busywait;
  logic                        mem_read;
  logic                        mem_write;
  logic [31-OFF:0]             mem_address;
  logic [32*BLOCK_WORDS-1:0]   mem_writedata;
  logic [32*BLOCK_WORDS-1:0]   mem_readdata;
  logic                        mem_busywait;

  modport master (
    output read, write, byteenable, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport slave (
    input  read, write, byteenable, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_assoc.sv
// Set-associative write-back, write-allocate data cache with true-LRU age counters.
// Hits complete in the request cycle; misses run WRITEBACK -> FETCH -> FILL.
module dcache_assoc #(
  parameter int unsigned WAYS        = 2,
  parameter int unsigned SETS        = 8,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input logic           clock,
  input logic           reset,
  dcache_assoc_if.slave bus
);
  localparam int unsigned OFF = $clog2(BLOCK_WORDS) + 2;
  localparam int unsigned IDX = $clog2(SETS);
  localparam int unsigned TAG = 32 - IDX - OFF;
  localparam int unsigned WB  = $clog2(BLOCK_WORDS);
  localparam int unsigned AW  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {StIdle, StWriteback, StFetch, StFill} state_e;

  state_e                    state_q;
  logic                      valid_q [SETS][WAYS];
  logic                      dirty_q [SETS][WAYS];
  logic [TAG-1:0]            tag_q   [SETS][WAYS];
  logic [AW-1:0]             age_q   [SETS][WAYS];
  logic [31:0]               data_q  [SETS][WAYS][BLOCK_WORDS];
  logic [AW-1:0]             victim_q;
  logic [32*BLOCK_WORDS-1:0] fill_q;
  logic                      mem_read_q, mem_write_q;

  logic [TAG-1:0] tag_in;
  logic [IDX-1:0] idx;
  logic [WB-1:0]  word;
  logic           req, hit_any, inv_any, hit, miss;
  logic [AW-1:0]  hit_way, inv_way, old_way, victim_sel, upd_way;
  logic [AW-1:0]  age_nxt [WAYS];

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [3:0] be,
                                             input logic [31:0] wd);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  assign tag_in = bus.address[31 -: TAG];
  assign idx    = bus.address[OFF+IDX-1:OFF];
  assign word   = bus.address[OFF-1:2];
  assign req    = bus.read | bus.write;

  // Descending scan so the lowest-index match/invalid way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    old_way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag_in) begin
        hit_any = 1'b1;
        hit_way = AW'(w);
      end
      if (!valid_q[idx][w]) begin
        inv_any = 1'b1;
        inv_way = AW'(w);
      end
      if (age_q[idx][w] == AW'(WAYS - 1)) old_way = AW'(w);
    end
  end

  assign hit        = req && hit_any;
  assign miss       = req && !hit_any;
  assign victim_sel = inv_any ? inv_way : old_way;

  // Accessed way becomes youngest; only ways younger than it age by one.
  always_comb begin
    upd_way = (state_q == StFill) ? victim_q : hit_way;
    for (int w = 0; w < int'(WAYS); w++) begin
      age_nxt[w] = age_q[idx][w];
      if (AW'(w) == upd_way) age_nxt[w] = '0;
      else if (age_q[idx][w] < age_q[idx][upd_way]) age_nxt[w] = age_q[idx][w] + AW'(1);
    end
  end

  assign bus.busywait  = (state_q != StIdle) || miss;
  assign bus.readdata  = data_q[idx][hit_way][word];
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_address = mem_write_q ? {tag_q[idx][victim_q], idx} : bus.address[31:OFF];

  always_comb begin
    bus.mem_writedata = '0;
    for (int i = 0; i < int'(BLOCK_WORDS); i++) begin
      bus.mem_writedata[32*i +: 32] = data_q[idx][victim_q][i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      victim_q    <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= AW'(w);
        end
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hit) begin
            for (int w = 0; w < int'(WAYS); w++) age_q[idx][w] <= age_nxt[w];
            if (bus.write && bus.byteenable != 4'b0000) dirty_q[idx][hit_way] <= 1'b1;
          end else if (miss) begin
            victim_q <= victim_sel;
            if (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel]) begin
              state_q     <= StWriteback;
              mem_write_q <= 1'b1;
            end else begin
              state_q    <= StFetch;
              mem_read_q <= 1'b1;
            end
          end
        end
        StWriteback: begin
          if (!bus.mem_busywait) begin
            state_q     <= StFetch;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
          end
        end
        StFetch: begin
          if (!bus.mem_busywait) begin
            state_q    <= StFill;
            mem_read_q <= 1'b0;
            fill_q     <= bus.mem_readdata;
          end
        end
        StFill: begin
          valid_q[idx][victim_q] <= 1'b1;
          dirty_q[idx][victim_q] <= bus.write;
          tag_q[idx][victim_q]   <= tag_in;
          for (int w = 0; w < int'(WAYS); w++) age_q[idx][w] <= age_nxt[w];
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Data array has no reset; updates are suppressed while reset is high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == StIdle && hit && bus.write) begin
        data_q[idx][hit_way][word] <=
          merge_word(data_q[idx][hit_way][word], bus.byteenable, bus.writedata);
      end else if (state_q == StFill) begin
        for (int i = 0; i < int'(BLOCK_WORDS); i++) begin
          data_q[idx][victim_q][i] <= (bus.write && WB'(i) == word) ?
            merge_word(fill_q[32*i +: 32], bus.byteenable, bus.writedata) : fill_q[32*i +: 32];
        end
      end
    end
  end
endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: word-level reference model, memory responder with one
// busy cycle per request, and a readdata scoreboard queue.
module tb_dcache_assoc;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0]  model_words [logic [31:0]];
  logic [31:0]  mem_words   [logic [31:0]];
  logic [31:0]  exp_q [$];
  logic [27:0]  last_wb_addr;
  logic [31:0]  exp_word;

  dcache_assoc_if #(.BLOCK_WORDS(4)) bus ();

  dcache_assoc #(.WAYS(2), .SETS(8), .BLOCK_WORDS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    return model_words.exists(wa) ? model_words[wa] : dflt(wa);
  endfunction

  function automatic void model_wr(input logic [31:0] a, input logic [3:0] be,
                                   input logic [31:0] wd);
    logic [31:0] v;
    v = model_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
    model_words[{a[31:2], 2'b00}] = v;
  endfunction

  function automatic logic [127:0] model_block(input logic [27:0] blk);
    logic [127:0] r;
    logic [1:0]   wi;
    for (int i = 0; i < 4; i++) begin
      wi = 2'(i);
      r[32*i +: 32] = model_rd({blk, wi, 2'b00});
    end
    return r;
  endfunction

  function automatic logic [127:0] mem_block(input logic [27:0] blk);
    logic [127:0] r;
    logic [31:0]  wa;
    logic [1:0]   wi;
    for (int i = 0; i < 4; i++) begin
      wi = 2'(i);
      wa = {blk, wi, 2'b00};
      r[32*i +: 32] = mem_words.exists(wa) ? mem_words[wa] : dflt(wa);
    end
    return r;
  endfunction

  function automatic void mem_store(input logic [27:0] blk, input logic [127:0] d);
    logic [1:0] wi;
    for (int i = 0; i < 4; i++) begin
      wi = 2'(i);
      mem_words[{blk, wi, 2'b00}] = d[32*i +: 32];
    end
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One CPU access, serviced to completion; counts memory traffic it caused.
  task automatic access(input string tag, input bit rd, input bit wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_fetch, input int exp_wb);
    int fetches, wbs, cyc, lat;
    bit both;
    fetches = 0; wbs = 0; cyc = 0; lat = 1; both = 1'b0;
    bus.read = rd; bus.write = wr; bus.byteenable = be; bus.address = addr;
    bus.writedata = wd;
    if (wr) model_wr(addr, be, wd);
    else exp_q.push_back(model_rd(addr));
    #1;
    while (bus.busywait && cyc < 40) begin
      if (bus.mem_read && bus.mem_write) both = 1'b1;
      if (bus.mem_read || bus.mem_write) begin
        if (lat == 0) begin
          bus.mem_busywait = 1'b0;
          lat = 1;
          if (bus.mem_write) begin
            wbs++;
            last_wb_addr = bus.mem_address;
            check({tag, "_wbdata"}, bus.mem_writedata, model_block(bus.mem_address));
            mem_store(bus.mem_address, bus.mem_writedata);
          end else begin
            fetches++;
            bus.mem_readdata = mem_block(bus.mem_address);
          end
        end else begin
          bus.mem_busywait = 1'b1;
          lat--;
        end
      end else begin
        bus.mem_busywait = 1'b1;
      end
      @(posedge clock);
      #2;
      cyc++;
    end
    bus.mem_busywait = 1'b1;
    check({tag, "_timeout"}, 128'(cyc < 40), 128'd1);
    if (!wr) begin
      exp_word = exp_q.pop_front();
      check({tag, "_rdata"}, bus.readdata, exp_word);
    end
    check({tag, "_fetches"}, 128'(fetches), 128'(exp_fetch));
    check({tag, "_wbs"}, 128'(wbs), 128'(exp_wb));
    check({tag, "_rd_wr_both"}, 128'(both), 128'd0);
    tick();
    bus.read = 1'b0;
    bus.write = 1'b0;
  endtask

  initial begin
    bus.read = 1'b0; bus.write = 1'b0; bus.byteenable = 4'h0; bus.address = '0;
    bus.writedata = '0; bus.mem_readdata = '0; bus.mem_busywait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      model_words[32'h10 + 32'(4*i)] = {4{8'(8'h11 * (i + 1))}};
      mem_words[32'h10 + 32'(4*i)]   = {4{8'(8'h11 * (i + 1))}};
    end
    model_words[32'h0] = 32'h1111_1111;
    mem_words[32'h0]   = 32'h1111_1111;

    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_busywait", 128'(bus.busywait), 128'd0);
    check("rst_mem_read", 128'(bus.mem_read), 128'd0);
    check("rst_mem_write", 128'(bus.mem_write), 128'd0);

    // Read-miss fill, cycle by cycle.
    bus.read = 1'b1; bus.address = 32'h10;
    exp_q.push_back(model_rd(32'h10));
    #1;
    check("miss_busy_same_cycle", 128'(bus.busywait), 128'd1);
    tick();
    check("fetch_mem_read", 128'(bus.mem_read), 128'd1);
    check("fetch_mem_write", 128'(bus.mem_write), 128'd0);
    check("fetch_mem_address", 128'(bus.mem_address), 128'h1);
    bus.mem_readdata = mem_block(28'h1);
    bus.mem_busywait = 1'b0;
    tick();
    bus.mem_busywait = 1'b1;
    check("fill_busy", 128'(bus.busywait), 128'd1);
    check("fill_mem_read", 128'(bus.mem_read), 128'd0);
    tick();
    check("after_fill_busy", 128'(bus.busywait), 128'd0);
    exp_word = exp_q.pop_front();
    check("after_fill_rdata", bus.readdata, exp_word);
    tick();
    bus.read = 1'b0;

    // LRU in set 0, including a clean eviction.
    access("lru_a",  1, 0, 4'h0, 32'h000, 0, 1, 0);
    access("lru_b",  1, 0, 4'h0, 32'h080, 0, 1, 0);
    access("lru_a2", 1, 0, 4'h0, 32'h000, 0, 0, 0);
    access("lru_c",  1, 0, 4'h0, 32'h100, 0, 1, 0);
    access("lru_a3", 1, 0, 4'h0, 32'h000, 0, 0, 0);
    access("clean",  1, 0, 4'h0, 32'h080, 0, 1, 0);

    // Byte write hit then dirty writeback.
    access("bw_hit",  0, 1, 4'b0011, 32'h000, 32'hAABB_CCDD, 0, 0);
    access("bw_rd",   1, 0, 4'h0, 32'h000, 0, 0, 0);
    check("bw_model", 128'(model_rd(32'h000)), 128'h1111_CCDD);
    access("bw_ev1",  1, 0, 4'h0, 32'h100, 0, 1, 0);
    access("bw_ev2",  1, 0, 4'h0, 32'h180, 0, 1, 1);
    check("wb_address", 128'(last_wb_addr), 128'h0);
    access("bw_back", 1, 0, 4'h0, 32'h000, 0, 1, 0);

    // Write miss into empty set 2, merge at fill, dirty eviction later.
    access("wm",      0, 1, 4'b1111, 32'h224, 32'hDEAD_BEEF, 1, 0);
    access("wm_rd",   1, 0, 4'h0, 32'h224, 0, 0, 0);
    access("wm_b",    1, 0, 4'h0, 32'h2A4, 0, 1, 0);
    access("wm_ev",   1, 0, 4'h0, 32'h324, 0, 1, 1);
    // Zero byteenable hit leaves the block clean.
    access("be0",     0, 1, 4'b0000, 32'h2A4, 32'hFFFF_FFFF, 0, 0);
    access("be0_rd",  1, 0, 4'h0, 32'h324, 0, 0, 0);
    access("be0_ev",  1, 0, 4'h0, 32'h3A4, 0, 1, 0);

    // Read and write together behave as a write.
    access("rw",      1, 1, 4'b1111, 32'h014, 32'h1234_5678, 0, 0);
    access("rw_rd",   1, 0, 4'h0, 32'h014, 0, 0, 0);

    // Reset while FETCH is stalled.
    bus.read = 1'b1; bus.address = 32'h410;
    tick();
    check("rstmid_fetch", 128'(bus.mem_read), 128'd1);
    reset = 1'b1;
    tick();
    check("rstmid_mem_read", 128'(bus.mem_read), 128'd0);
    check("rstmid_mem_write", 128'(bus.mem_write), 128'd0);
    reset = 1'b0;
    bus.read = 1'b0;
    tick();
    access("rstmid_reread", 1, 0, 4'h0, 32'h410, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
